// File: rtl/pic_pkg.sv
// Shared definitions for the 8259 interrupt-acknowledge sequencer: control state
// encodings, the MCS-80 CALL opcode and a one-hot to binary IR index helper.
package pic_pkg;

   typedef enum logic [1:0] {
      CTL_READY = 2'd0,
      CTL_ACK1  = 2'd1,
      CTL_ACK2  = 2'd2,
      CTL_ACK3  = 2'd3
   } control_state_t;

   localparam logic [7:0] CALL_OPCODE = 8'hCD;

   // Lowest set bit wins; an all-zero input maps to index 0.
   function automatic logic [2:0] onehot_to_index(input logic [7:0] onehot);
      logic [2:0] index;
      index = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (onehot[i]) index = 3'(i);
      end
      return index;
   endfunction

endpackage

// File: rtl/pic_inta_edge_detect.sv
// Falling/rising edge detector for the already-synchronised INTA strobe.
// The delay flop idles high so a pin held low through reset is not seen as a fall.
module pic_inta_edge_detect (
   input  logic clock,
   input  logic reset_n,
   input  logic init,
   input  logic inta_level,
   output logic fall,
   output logic rise
);

   logic inta_prev;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         inta_prev <= 1'b1;
      end else if (init) begin
         inta_prev <= 1'b1;
      end else begin
         inta_prev <= inta_level;
      end
   end

   assign fall = inta_prev & ~inta_level;
   assign rise = ~inta_prev & inta_level;

endmodule

// File: rtl/pic_interrupt_ack_sequencer.sv
// 8259 INTA sequencer: steps READY/ACK1/ACK2/ACK3 on INTA edges, latches the winning
// IR, pulses the ISR set, and drives the vector/CALL bytes and master cascade ID.
module pic_interrupt_ack_sequencer #(
   parameter int         SPURIOUS_IR = 7,
   parameter logic [7:0] CALL_OPCODE = pic_pkg::CALL_OPCODE
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       interrupt_acknowledge_n,
   input  logic       write_initial_command_word_1,
   input  logic       u8086_or_mcs80_config,
   input  logic       single_or_cascade_config,
   input  logic       cascade_slave,
   input  logic       cascade_slave_enable,
   input  logic [7:0] cascade_device_config,
   input  logic [7:0] highest_priority_request,
   input  logic [7:0] interrupt_vector_base,
   input  logic [2:0] call_address_low,
   output logic [1:0] control_state,
   output logic [7:0] acknowledge_interrupt,
   output logic [7:0] in_service_set,
   output logic       end_of_acknowledge,
   output logic [2:0] cascade_out,
   output logic       cascade_out_enable,
   output logic [7:0] data_out,
   output logic       data_out_enable
);

   import pic_pkg::*;

   control_state_t state_reg, state_next;
   logic           mode_8086_reg;
   logic           spurious_reg;
   logic           entered_reg;
   logic           fall, rise;
   logic           start_ack, end_ack, enter_ack;
   logic [2:0]     ir_index;
   logic           is_master, has_slave, owns_vector;
   logic [7:0]     load_value;
   logic           load_drive;

   pic_inta_edge_detect u_edge (
      .clock      (clock),
      .reset_n    (reset_n),
      .init       (write_initial_command_word_1),
      .inta_level (interrupt_acknowledge_n),
      .fall       (fall),
      .rise       (rise)
   );

   assign ir_index    = spurious_reg ? 3'(SPURIOUS_IR) : onehot_to_index(acknowledge_interrupt);
   assign is_master   = ~single_or_cascade_config & ~cascade_slave;
   assign has_slave   = |(acknowledge_interrupt & cascade_device_config);
   assign owns_vector = single_or_cascade_config
                      | (cascade_slave & cascade_slave_enable)
                      | (is_master & ~has_slave);

   always_comb begin
      state_next = state_reg;
      start_ack  = 1'b0;
      end_ack    = 1'b0;
      unique case (state_reg)
         CTL_READY: if (fall) begin
            state_next = CTL_ACK1;
            start_ack  = 1'b1;
         end
         CTL_ACK1: if (fall) state_next = CTL_ACK2;
         CTL_ACK2: begin
            if (fall && !mode_8086_reg) begin
               state_next = CTL_ACK3;
            end else if (rise && mode_8086_reg) begin
               state_next = CTL_READY;
               end_ack    = 1'b1;
            end
         end
         CTL_ACK3: if (rise) begin
            state_next = CTL_READY;
            end_ack    = 1'b1;
         end
         default: state_next = CTL_READY;
      endcase
      enter_ack = (state_next != state_reg) && (state_next != CTL_READY);
   end

   // Byte and drive decision for the ACK state just entered; loaded one cycle later.
   always_comb begin
      load_value = data_out;
      load_drive = 1'b0;
      unique case (state_reg)
         CTL_ACK1: if (!mode_8086_reg) begin
            load_value = CALL_OPCODE;
            load_drive = single_or_cascade_config | ~cascade_slave;
         end
         CTL_ACK2: begin
            load_value = mode_8086_reg ? {interrupt_vector_base[7:3], ir_index}
                                       : {call_address_low, ir_index, 2'b00};
            load_drive = owns_vector;
         end
         CTL_ACK3: begin
            load_value = interrupt_vector_base;
            load_drive = owns_vector;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg             <= CTL_READY;
         mode_8086_reg         <= 1'b0;
         spurious_reg          <= 1'b0;
         entered_reg           <= 1'b0;
         acknowledge_interrupt <= 8'h00;
         in_service_set        <= 8'h00;
         end_of_acknowledge    <= 1'b0;
         cascade_out           <= 3'd0;
         cascade_out_enable    <= 1'b0;
         data_out              <= 8'h00;
         data_out_enable       <= 1'b0;
      end else if (write_initial_command_word_1) begin
         state_reg             <= CTL_READY;
         mode_8086_reg         <= 1'b0;
         spurious_reg          <= 1'b0;
         entered_reg           <= 1'b0;
         acknowledge_interrupt <= 8'h00;
         in_service_set        <= 8'h00;
         end_of_acknowledge    <= 1'b0;
         cascade_out           <= 3'd0;
         cascade_out_enable    <= 1'b0;
         data_out              <= 8'h00;
         data_out_enable       <= 1'b0;
      end else begin
         state_reg          <= state_next;
         entered_reg        <= enter_ack;
         end_of_acknowledge <= end_ack;
         in_service_set     <= start_ack ? highest_priority_request : 8'h00;
         if (start_ack) begin
            acknowledge_interrupt <= highest_priority_request;
            spurious_reg          <= (highest_priority_request == 8'h00);
            mode_8086_reg         <= u8086_or_mcs80_config;
         end
         if (end_ack) begin
            acknowledge_interrupt <= 8'h00;
            cascade_out           <= 3'd0;
            cascade_out_enable    <= 1'b0;
            data_out_enable       <= 1'b0;
         end else if (rise) begin
            data_out_enable <= 1'b0;
         end else if (entered_reg) begin
            data_out        <= load_value;
            data_out_enable <= load_drive;
            if (state_reg == CTL_ACK1) begin
               cascade_out_enable <= is_master & has_slave;
               cascade_out        <= (is_master & has_slave) ? ir_index : 3'd0;
            end
         end
      end
   end

   assign control_state = state_reg;

endmodule

// File: doc/pic_interrupt_ack_sequencer.md
Name: pic_interrupt_ack_sequencer

Overview:
- Controls the 8259 interrupt-acknowledge (INTA) sequence.
- Samples the CPU INTA strobe, steps through the ACK states, and latches the winning request from the priority resolver.
- Pulses the in-service set, chooses the byte placed on the data bus, and drives the cascade ID and acknowledge vector used by the cascade block.
- Supports 8086 mode (two INTA pulses) and MCS-80/85 mode (three pulses), in single or cascaded systems.

Parameters:
- SPURIOUS_IR, 7, IR index whose vector is returned when no request is pending at ACK1.
- CALL_OPCODE, 8'hCD, byte driven on the first INTA pulse in MCS-80 mode.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset_n  input  1  asynchronous active-low reset.
- interrupt_acknowledge_n  input  1  CPU INTA strobe, already synchronised, active low.
- write_initial_command_word_1  input  1  synchronous re-initialisation strobe.
- u8086_or_mcs80_config  input  1  1 = 8086 mode, 0 = MCS-80 mode (ICW4 uPM).
- single_or_cascade_config  input  1  1 = single device (ICW1 SNGL).
- cascade_slave  input  1  device is a cascaded slave.
- cascade_slave_enable  input  1  this slave has been addressed by the CAS lines.
- cascade_device_config  input  8  master: IR lines that have slaves attached.
- highest_priority_request  input  8  one-hot winning IR from the resolver; all zero = none.
- interrupt_vector_base  input  8  ICW2 (T7-T3 in 8086 mode; A15-A8 in MCS-80 mode).
- call_address_low  input  3  ICW1 A7-A5.
- control_state  output  2  READY=0, ACK1=1, ACK2=2, ACK3=3.
- acknowledge_interrupt  output  8  one-hot IR latched at ACK1; held until end of sequence.
- in_service_set  output  8  one-cycle pulse that sets the ISR bit.
- end_of_acknowledge  output  1  one-cycle pulse when the sequence completes.
- cascade_out  output  3  slave ID driven by the master.
- cascade_out_enable  output  1  master drives the CAS lines.
- data_out  output  8  byte for the data bus.
- data_out_enable  output  1  data bus drive enable.

Behaviour:
- Reset values (reset_n low, async): every output 0, control_state=READY, internal INTA delay flop=1.
- write_initial_command_word_1=1 gives the same reset, but synchronously; it has priority over every other event in that cycle.
- Edge detection: a registered copy of interrupt_acknowledge_n.
  - Falling edge = previous 1, current 0.
  - Rising edge = previous 0, current 1.
  - Each edge is detected in the cycle after the pin changes.
- Transitions, evaluated on falling edges:
  - READY -> ACK1.
  - ACK1 -> ACK2.
  - ACK2 -> ACK3, in MCS-80 mode only.
- Sequence end, evaluated on rising edges:
  - 8086 mode: end on the rising edge while in ACK2.
  - MCS-80 mode: end on the rising edge while in ACK3.
  - At end: pulse end_of_acknowledge for 1 cycle, go to READY, clear acknowledge_interrupt, cascade_out, cascade_out_enable and data_out_enable.
- Rising edges in ACK1 (and in ACK2 in MCS-80 mode) change no state.
- At the READY->ACK1 transition:
  - acknowledge_interrupt <= highest_priority_request.
  - in_service_set pulses that same value for exactly 1 cycle.
  - If highest_priority_request is zero (spurious): acknowledge_interrupt=0, no in_service_set pulse, vector index = SPURIOUS_IR.
- IR index = binary encoding of acknowledge_interrupt. Spurious uses SPURIOUS_IR.
- Master cascade mode: single_or_cascade_config=0 and cascade_slave=0.
  - If (acknowledge_interrupt & cascade_device_config) != 0, then cascade_out = IR index and cascade_out_enable=1.
  - Both hold from the cycle after the ACK1 edge until end of sequence; otherwise both are 0.
- Drive rule: the device "owns the vector" when:
  - single mode; or
  - slave with cascade_slave_enable=1; or
  - master whose acked IR has no slave.
- data_out and data_out_enable are registered and update in the cycle after the state change.
  - 8086 mode, ACK1: no drive.
  - 8086 mode, ACK2: {interrupt_vector_base[7:3], IR index}, driven if the device owns the vector.
  - MCS-80 mode, ACK1: CALL_OPCODE, driven by the master or single device only (never a slave).
  - MCS-80 mode, ACK2: {call_address_low, IR index, 2'b00} (interval 4), driven if the device owns the vector.
  - MCS-80 mode, ACK3: interrupt_vector_base, driven if the device owns the vector.
  - data_out_enable drops to 0 on every rising edge of INTA; data_out keeps its value.
- Mode change mid-sequence: the mode is sampled at ACK1 and held until the sequence ends.
- Asynchronous reset mid-sequence returns to READY immediately, with no end_of_acknowledge pulse.
- Falling and rising edges cannot occur in the same cycle, by construction.

Decomposition:
- Shared package pic_pkg:
  - control_state encodings (CTL_READY, ACK1, ACK2, ACK3).
  - CALL_OPCODE.
  - Function onehot_to_index (8->3, lowest set bit wins; 0 for all-zero input).
- Sub-module pic_inta_edge_detect: sync-level INTA in, fall/rise pulses out; async reset to the idle-high state.

Test Plan:
1. 8086, single, request 8'b0000_0100, base 8'h40, two INTA pulses -> in_service_set=8'h04 for 1 cycle after the first fall; ACK2 data_out=8'h42 with enable=1; end_of_acknowledge pulses on the second rise; state returns to READY.
2. MCS-80, single, request IR5, call_address_low=3'b101, base 8'h12, three pulses -> data_out sequence 8'hCD, 8'hB4, 8'h12; end pulses after the third rise.
3. Master, 8086, cascade_device_config=8'h08, request IR3 -> cascade_out=3'd3 with enable=1 from ACK1 to end; data_out_enable stays 0.
4. Slave with cascade_slave_enable=1, MCS-80, request IR0 -> ACK1 not driven; ACK2 and ACK3 driven; cascade_out_enable=0.
5. Spurious, 8086, request 0, base 8'h80 -> no in_service_set pulse; ACK2 data_out=8'h87.
6. reset_n low during ACK2 -> all outputs 0 immediately with no end pulse; next INTA fall enters ACK1.
